// File: rtl/ma_filter_bank_pkg.sv
// package_settings: shared widths and default sizing for ma_filter_bank.
package package_settings;
    localparam int SIZE_ADC_DATA = 12;
    localparam int MA_N_CH_DEFAULT = 6;
    localparam int MA_WINDOW_LOG2_DEFAULT = 3;
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/ma_filter_bank_if.sv
// ma_filter_bank_if: sample/result bundle between a sample source (master) and ma_filter_bank (slave).
interface ma_filter_bank_if #(
    parameter int N_CH = package_settings::MA_N_CH_DEFAULT,
    parameter int WINDOW_LOG2 = package_settings::MA_WINDOW_LOG2_DEFAULT,
    parameter int SIZE_IN = package_settings::SIZE_ADC_DATA
);
    import package_settings::*;
    localparam int SIZE_SUM = SIZE_IN + WINDOW_LOG2;
    localparam int SEL_W = sel_width(N_CH);
    logic [N_CH*SIZE_IN-1:0] input_data;
    logic in_valid;
    logic [SEL_W-1:0] sel;
    logic peak_clear;
    logic [SIZE_SUM-1:0] output_data;
    logic out_valid;
    logic [SIZE_IN-1:0] output_avg;
    logic [SIZE_SUM-1:0] peak_data;
    modport master (
        output input_data, in_valid, sel, peak_clear,
        input output_data, out_valid, output_avg, peak_data
    );
    modport slave (
        input input_data, in_valid, sel, peak_clear,
        output output_data, out_valid, output_avg, peak_data
    );
endinterface

// File: rtl/ma_filter_bank_channel.sv
// ma_channel: one channel's circular delay line and running window sum.
module ma_channel import package_settings::*; #(
    parameter int WINDOW_LOG2 = MA_WINDOW_LOG2_DEFAULT,
    parameter int SIZE_IN = SIZE_ADC_DATA
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic [WINDOW_LOG2-1:0] wr_ptr,
    input  logic [SIZE_IN-1:0] x_in,
    output logic [SIZE_IN+WINDOW_LOG2-1:0] sum_d
);
    localparam int SIZE_SUM = SIZE_IN + WINDOW_LOG2;
    localparam int DEPTH = 1 << WINDOW_LOG2;
    logic [SIZE_IN-1:0] line_q [DEPTH];
    logic [SIZE_IN-1:0] line_d [DEPTH];
    logic [SIZE_SUM-1:0] sum_q;
    // The slot at wr_ptr still holds the sample leaving the window.
    always_comb begin
        line_d = line_q;
        line_d[wr_ptr] = in_valid ? x_in : line_q[wr_ptr];
        sum_d = in_valid ? sum_q + SIZE_SUM'(x_in) - SIZE_SUM'(line_q[wr_ptr]) : sum_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            line_q <= '{default: '0};
            sum_q <= '0;
        end else begin
            line_q <= line_d;
            sum_q <= sum_d;
        end
    end
endmodule

// File: rtl/ma_filter_bank.sv
// ma_filter_bank: N_CH parallel moving-sum filters with a registered output mux.
// Define MA_FILTER_BANK_PEAK_HOLD_EN to add the peak-hold register on peak_data.
module ma_filter_bank import package_settings::*; #(
    parameter int N_CH = MA_N_CH_DEFAULT,
    parameter int WINDOW_LOG2 = MA_WINDOW_LOG2_DEFAULT,
    parameter int SIZE_IN = SIZE_ADC_DATA
) (
    input logic clk,
    input logic reset,
    ma_filter_bank_if.slave bus
);
    localparam int SIZE_SUM = SIZE_IN + WINDOW_LOG2;
    localparam int SEL_W = sel_width(N_CH);
    logic [WINDOW_LOG2-1:0] ptr_q, ptr_d;
    logic [WINDOW_LOG2:0] fill_q, fill_d;
    logic [SIZE_SUM-1:0] data_q, data_d;
    logic [SIZE_IN-1:0] avg_q, avg_d;
    logic out_valid_q, out_valid_d;
    logic [SIZE_SUM-1:0] sums [2**SEL_W];
    // Unused mux slots read as zero, which covers sel >= N_CH.
    for (genvar g = 0; g < 2**SEL_W; g++) begin : g_ch
        if (g < N_CH) begin : g_real
            ma_channel #(.WINDOW_LOG2(WINDOW_LOG2), .SIZE_IN(SIZE_IN)) u_ch (
                .clk(clk),
                .reset(reset),
                .in_valid(bus.in_valid),
                .wr_ptr(ptr_q),
                .x_in(bus.input_data[g*SIZE_IN +: SIZE_IN]),
                .sum_d(sums[g])
            );
        end else begin : g_pad
            assign sums[g] = '0;
        end
    end
    // fill_q saturates at 2**WINDOW_LOG2, so its top bit alone means "window full".
    always_comb begin
        ptr_d = bus.in_valid ? ptr_q + 1'b1 : ptr_q;
        fill_d = (bus.in_valid && !fill_q[WINDOW_LOG2]) ? fill_q + 1'b1 : fill_q;
        out_valid_d = bus.in_valid && (fill_q[WINDOW_LOG2] || &fill_q[WINDOW_LOG2-1:0]);
        data_d = bus.in_valid ? sums[bus.sel] : data_q;
        avg_d = data_d[SIZE_SUM-1:WINDOW_LOG2];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            fill_q <= '0;
            data_q <= '0;
            avg_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            fill_q <= fill_d;
            data_q <= data_d;
            avg_q <= avg_d;
            out_valid_q <= out_valid_d;
        end
    end
    assign bus.output_data = data_q;
    assign bus.output_avg = avg_q;
    assign bus.out_valid = out_valid_q;
`ifdef MA_FILTER_BANK_PEAK_HOLD_EN
    logic [SIZE_SUM-1:0] peak_q, peak_d;
    // A clear coinciding with a valid result restarts the peak from that result.
    always_comb
        peak_d = bus.peak_clear ? (out_valid_d ? data_d : '0)
               : (out_valid_d && data_d > peak_q) ? data_d : peak_q;
    always_ff @(posedge clk) begin
        if (reset) peak_q <= '0;
        else peak_q <= peak_d;
    end
    assign bus.peak_data = peak_q;
`else
    assign bus.peak_data = '0;
`endif
endmodule

// File: tb/tb_ma_filter_bank.sv
// tb_ma_filter_bank: scoreboard bench for ma_filter_bank with N_CH=6, WINDOW_LOG2=3, SIZE_IN=12.
module tb_ma_filter_bank;
    localparam int NC = 6, WL = 3, SI = 12, SS = SI + WL, SW = 3;
`ifdef MA_FILTER_BANK_PEAK_HOLD_EN
    localparam bit PEAK = 1'b1;
`else
    localparam bit PEAK = 1'b0;
`endif
    typedef struct packed {
        logic [SS-1:0] out;
        logic [SI-1:0] avg;
        logic vld;
        logic [SS-1:0] peak;
    } obs_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    ma_filter_bank_if #(.N_CH(NC), .WINDOW_LOG2(WL), .SIZE_IN(SI)) bus ();
    ma_filter_bank #(.N_CH(NC), .WINDOW_LOG2(WL), .SIZE_IN(SI)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    int checks = 0, errors = 0;
    obs_t sb[$];
    obs_t got, exp;
    int hist [NC][$];
    int m_cnt = 0, m_out = 0, m_peak = 0;
    logic [SI-1:0] din [NC];

    function automatic obs_t observe();
        obs_t o;
        o.out = bus.output_data;
        o.avg = bus.output_avg;
        o.vld = bus.out_valid;
        o.peak = bus.peak_data;
        return o;
    endfunction

    // Drive one cycle, push the model's expectation, then wait until just after the edge.
    task automatic step(input bit v, input int s, input bit pc, input bit r);
        obs_t e;
        bit vld;
        int sum;
        @(negedge clk);
        reset = r;
        bus.in_valid = v;
        bus.sel = SW'(s);
        bus.peak_clear = pc;
        for (int k = 0; k < NC; k++) bus.input_data[k*SI +: SI] = din[k];
        vld = 1'b0;
        if (r) begin
            for (int k = 0; k < NC; k++) hist[k].delete();
            m_cnt = 0;
            m_out = 0;
            m_peak = 0;
        end else if (v) begin
            for (int k = 0; k < NC; k++) begin
                hist[k].push_back(int'(din[k]));
                if (hist[k].size() > 8) void'(hist[k].pop_front());
            end
            m_cnt++;
            sum = 0;
            if (s < NC) for (int i = 0; i < hist[s].size(); i++) sum += hist[s][i];
            m_out = sum;
            vld = m_cnt >= 8;
            if (pc) m_peak = vld ? m_out : 0;
            else if (vld && m_out > m_peak) m_peak = m_out;
        end else if (pc) begin
            m_peak = 0;
        end
        e.out = SS'(m_out);
        e.avg = SI'(m_out / 8);
        e.vld = vld;
        e.peak = PEAK ? SS'(m_peak) : '0;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fill_din(input int v);
        for (int k = 0; k < NC; k++) din[k] = SI'(v);
    endtask

    task automatic test_reset();
        fill_din(0);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 0, 1'b1, 1'b1);
            got = observe(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL reset[%0d] got %p want %p", i, got, exp); end
        end
    endtask

    task automatic test_ramp();
        step(1'b0, 0, 1'b0, 1'b1);
        void'(sb.pop_front());
        for (int i = 1; i <= 10; i++) begin
            for (int k = 1; k < NC; k++) din[k] = SI'($urandom_range(0, 4095));
            din[0] = 12'd100;
            step(1'b1, 0, 1'b0, 1'b0);
            got = observe(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL ramp[%0d] got %p want %p", i, got, exp); end
            checks++;
            if (got.out !== SS'(100 * (i < 8 ? i : 8)) || got.vld !== (i >= 8)) begin
                errors++; $display("FAIL ramp_const[%0d] out=%0d vld=%0b", i, got.out, got.vld);
            end
        end
        checks++;
        if (bus.output_avg !== 12'd100) begin errors++; $display("FAIL ramp_avg got %0d want 100", bus.output_avg); end
    endtask

    task automatic test_full_scale();
        step(1'b0, 5, 1'b0, 1'b1);
        void'(sb.pop_front());
        fill_din(4095);
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 5, 1'b0, 1'b0);
            got = observe(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL full_scale[%0d] got %p want %p", i, got, exp); end
        end
        checks++;
        if (bus.output_data !== 15'd32760 || bus.output_avg !== 12'd4095 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL full_scale_const out=%0d avg=%0d want 32760/4095", bus.output_data, bus.output_avg);
        end
    endtask

    task automatic test_impulse();
        step(1'b0, 3, 1'b0, 1'b1);
        void'(sb.pop_front());
        for (int i = 1; i <= 9; i++) begin
            fill_din(0);
            if (i == 1) din[3] = 12'd1000;
            step(1'b1, 3, 1'b0, 1'b0);
            got = observe(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL impulse[%0d] got %p want %p", i, got, exp); end
            checks++;
            if (got.out !== (i <= 8 ? SS'(1000) : SS'(0))) begin
                errors++; $display("FAIL impulse_const[%0d] out=%0d", i, got.out);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1, 1'b0, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 14; i++) begin
            for (int k = 0; k < NC; k++) din[k] = SI'($urandom_range(0, 4095));
            step(i != 5, 1, 1'b0, i == 5);
            got = observe(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL reset_mid[%0d] got %p want %p", i, got, exp); end
            checks++;
            if (got.vld !== (i == 13)) begin errors++; $display("FAIL reset_mid_vld[%0d] got %0b", i, got.vld); end
        end
    endtask

    task automatic test_sel();
        int sels [6] = '{7, 2, 4, 4, 6, 4};
        bit vals [6] = '{1, 1, 0, 0, 1, 1};
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < NC; k++) din[k] = SI'(100 * (k + 1) + i);
            step(vals[i], sels[i], 1'b0, 1'b0);
            got = observe(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL sel[%0d] got %p want %p", i, got, exp); end
        end
    endtask

    task automatic test_peak();
        step(1'b0, 0, 1'b0, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 17; i++) begin
            fill_din(0);
            din[0] = (i < 8) ? 12'd100 : (i < 16) ? 12'd50 : 12'd60;
            step(1'b1, 0, i == 16, 1'b0);
            got = observe(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL peak[%0d] got %p want %p", i, got, exp); end
            if (i == 15) begin
                checks++;
                if (got.out !== 15'd400 || got.peak !== (PEAK ? 15'd800 : 15'd0)) begin
                    errors++; $display("FAIL peak_hold out=%0d peak=%0d", got.out, got.peak);
                end
            end
        end
        checks++;
        if (bus.peak_data !== (PEAK ? 15'd410 : 15'd0)) begin
            errors++; $display("FAIL peak_clear got %0d", bus.peak_data);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            for (int k = 0; k < NC; k++) din[k] = SI'($urandom_range(0, 4095));
            step($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 49) == 0);
            got = observe(); exp = sb.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL random[%0d] got %p want %p", i, got, exp); end
        end
    endtask

    initial begin
        bus.input_data = '0;
        bus.in_valid = 1'b0;
        bus.sel = '0;
        bus.peak_clear = 1'b0;
        fill_din(0);
        test_reset();
        test_ramp();
        test_full_scale();
        test_impulse();
        test_reset_mid();
        test_sel();
        test_peak();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ma_filter_bank.md
MA_FILTER_BANK -- requirements
Module: ma_filter_bank

Interface
REQ-001 Parameter N_CH, default 6: number of parallel input channels, range 1..16.
REQ-002 Parameter WINDOW_LOG2, default 3: moving-sum window is 2**WINDOW_LOG2 samples, range 1..8.
REQ-003 Parameter SIZE_IN, default SIZE_ADC_DATA: unsigned sample width per channel.
REQ-004 Derived width SIZE_SUM = SIZE_IN + WINDOW_LOG2: accumulator and output width.
REQ-005 clk  input  1: single clock; all state updates on its rising edge.
REQ-006 reset  input  1: synchronous, active-high reset.
REQ-007 input_data  input  N_CH*SIZE_IN: packed samples; channel k occupies bits [k*SIZE_IN +: SIZE_IN].
REQ-008 in_valid  input  1: sample strobe; all channels advance together when high.
REQ-009 sel  input  max(1,$clog2(N_CH)): channel routed to output_data.
REQ-010 peak_clear  input  1: clears the peak-hold register (only with PEAK_HOLD_EN).
REQ-011 output_data  output  SIZE_SUM: registered moving sum of the selected channel.
REQ-012 out_valid  output  1: one-cycle pulse; output_data holds a full-window sum.
REQ-013 output_avg  output  SIZE_IN: output_data >> WINDOW_LOG2, truncated, registered with output_data.
REQ-014 peak_data  output  SIZE_SUM: running maximum of valid output_data (only with PEAK_HOLD_EN).

Function
REQ-015 On each clk edge with in_valid=1, every channel SHALL update sum <= sum + x_new - x_old, where x_old is the sample written 2**WINDOW_LOG2 strobes earlier.
REQ-016 Each channel SHALL hold a circular delay line of 2**WINDOW_LOG2 entries, shared write pointer, wrapping from 2**WINDOW_LOG2-1 to 0.
REQ-017 Arithmetic SHALL be unsigned at SIZE_SUM width; no overflow is possible, no saturation logic.
REQ-018 With in_valid=0, sums, pointer, fill counter and outputs SHALL hold; out_valid SHALL be 0.
REQ-019 Latency: output_data/output_avg SHALL reflect the sum including the sample strobed at edge n, valid after edge n (one clock).
REQ-020 sel SHALL be sampled on in_valid edges only; a sel change between strobes takes effect on the next strobe.
REQ-021 sel >= N_CH SHALL drive output_data=0 and output_avg=0 at the next strobe; out_valid behaves normally.
REQ-022 Fill counter SHALL count strobes, saturating at 2**WINDOW_LOG2; out_valid SHALL pulse only for strobes where the counter reaches or has reached 2**WINDOW_LOG2 (first pulse on the 2**WINDOW_LOG2-th strobe).
REQ-023 Before fill, output_data SHALL still update with partial sums (delay line zeroed), out_valid low.

Reset
REQ-024 reset=1 SHALL clear all sums, delay lines, write pointer, fill counter, output_data, output_avg, out_valid and peak_data to 0 at the next edge.
REQ-025 reset SHALL take priority over in_valid and peak_clear; reset mid-window restarts fill from zero.

Configuration
REQ-026 Macro MA_FILTER_BANK_PEAK_HOLD_EN defined: peak_data SHALL update to max(peak_data, new output_data) on each out_valid strobe; peak_clear=1 zeros it.
REQ-027 peak_clear and out_valid on the same edge: peak_data SHALL load the new output_data.
REQ-028 Macro undefined: peak_data SHALL be tied to 0, peak_clear ignored, no peak register synthesised.

Structure
REQ-029 package_settings SHALL hold SIZE_ADC_DATA and new constants MA_N_CH_DEFAULT and MA_WINDOW_LOG2_DEFAULT.
REQ-030 Sub-module ma_channel (delay line + accumulator, one per channel) SHALL be instantiated N_CH times by generate; selection mux and peak hold stay in ma_filter_bank.

Verification (N_CH=6, WINDOW_LOG2=3, SIZE_IN=12)
REQ-031 Channel 0 held at 100, sel=0, 10 strobes -> output_data 100,200,...,800,800,800; out_valid first on strobe 8; output_avg=100 from strobe 8.
REQ-032 All channels 4095, sel=5, 8 strobes -> output_data=32760, output_avg=4095, no overflow.
REQ-033 Impulse 1000 on channel 3 then zeros, sel=3 -> output_data 1000 for 8 strobes, 0 on strobe 9 (wrap-around).
REQ-034 Reset asserted after strobe 5 -> all outputs 0 next edge; next 7 strobes out_valid=0, pulses on 8th.
REQ-035 sel=7 -> output_data=0; sel changed without in_valid -> output unchanged until next strobe.
REQ-036 PEAK_HOLD_EN: ramp to 800 then down to 400 -> peak_data=800; peak_clear with strobe -> peak_data=current output_data.
